// File: rtl/csr_unit_if.sv
// Pipeline-to-CSR bus: decode read port, writeback commit signals, and the
// entry/return/interrupt values returned to fetch and decode.
interface csr_unit_if;
    logic [13:0] rd_addr;
    logic [31:0] rd_data;
    logic        csr_wr_en;
    logic [13:0] wr_csr_addr;
    logic [31:0] wr_csr_data;
    logic        excp_flush;
    logic        ertn_flush;
    logic [31:0] csr_era;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic        va_error;
    logic [31:0] bad_va;
    logic        excp_tlbrefill;
    logic        ws_llbit_set;
    logic        ws_llbit;
    logic [31:0] excp_entry;
    logic [31:0] ertn_pc;
    logic        has_int;
    logic        llbit;
    logic [1:0]  crmd_plv;

    modport master (
        output rd_addr, csr_wr_en, wr_csr_addr, wr_csr_data, excp_flush, ertn_flush,
               csr_era, csr_ecode, csr_esubcode, va_error, bad_va, excp_tlbrefill,
               ws_llbit_set, ws_llbit,
        input  rd_data, excp_entry, ertn_pc, has_int, llbit, crmd_plv
    );

    modport slave (
        input  rd_addr, csr_wr_en, wr_csr_addr, wr_csr_data, excp_flush, ertn_flush,
               csr_era, csr_ecode, csr_esubcode, va_error, bad_va, excp_tlbrefill,
               ws_llbit_set, ws_llbit,
        output rd_data, excp_entry, ertn_pc, has_int, llbit, crmd_plv
    );
endinterface

// File: rtl/csr_unit.sv
// LoongArch32 CSR file: exception/ertn state, constant timer, interrupt
// sampling and llbit tracking. Only architecturally writable bits are stored.
module csr_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hw_int,
    input  logic       ipi,
    csr_unit_if.slave  csr
);
    localparam logic [13:0] CSR_CRMD   = 14'h00, CSR_PRMD   = 14'h01, CSR_ECFG  = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05, CSR_ERA    = 14'h06, CSR_BADV  = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0C, CSR_SAVE0  = 14'h30, CSR_SAVE1 = 14'h31;
    localparam logic [13:0] CSR_SAVE2  = 14'h32, CSR_SAVE3  = 14'h33, CSR_TID   = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41, CSR_TVAL   = 14'h42, CSR_TICLR = 14'h44;
    localparam logic [13:0] CSR_LLBCTL = 14'h60, CSR_TLBRENTRY = 14'h88;

    typedef struct packed {
        logic [1:0]       plv;
        logic             ie;
        logic             da;
        logic             pg;
        logic [1:0]       pplv;
        logic             pie;
        logic [12:0]      lie;
        logic [12:0]      estat_is;
        logic [5:0]       ecode;
        logic [8:0]       esubcode;
        logic [31:0]      era;
        logic [31:0]      badv;
        logic [25:0]      eentry;
        logic [25:0]      tlbrentry;
        logic [3:0][31:0] save;
        logic [31:0]      tid;
        logic             tcfg_en;
        logic             tcfg_per;
        logic [29:0]      tcfg_init;
        logic [31:0]      tval;
        logic             llbit;
        logic             klo;
    } csr_state_t;

    csr_state_t  st_q, st_d;
    logic        wr, tcfg_wr, ticlr_clr, timer_fire;
    logic [31:0] rd_val;
    logic [31:0] wd;

    always_comb begin
        wd         = csr.wr_csr_data;
        wr         = csr.csr_wr_en && !csr.excp_flush && !csr.ertn_flush;
        tcfg_wr    = wr && (csr.wr_csr_addr == CSR_TCFG);
        ticlr_clr  = wr && (csr.wr_csr_addr == CSR_TICLR) && wd[0];
        timer_fire = st_q.tcfg_en && !tcfg_wr && (st_q.tval == 32'd1);
    end

    always_comb begin
        st_d = st_q;
        // Interrupt lines are re-sampled every cycle regardless of commits.
        st_d.estat_is[9:2] = hw_int;
        st_d.estat_is[10]  = 1'b0;
        st_d.estat_is[12]  = ipi;

        if (tcfg_wr) begin
            if (wd[0]) st_d.tval = {wd[31:2], 2'b00};
        end else if (st_q.tcfg_en) begin
            if (st_q.tval != 32'd0)  st_d.tval = st_q.tval - 32'd1;
            else if (st_q.tcfg_per)  st_d.tval = {st_q.tcfg_init, 2'b00};
        end
        if (timer_fire)     st_d.estat_is[11] = 1'b1;
        else if (ticlr_clr) st_d.estat_is[11] = 1'b0;

        if (csr.ws_llbit_set) st_d.llbit = csr.ws_llbit;

        if (csr.excp_flush) begin
            st_d.pplv     = st_q.plv;
            st_d.pie      = st_q.ie;
            st_d.plv      = 2'd0;
            st_d.ie       = 1'b0;
            st_d.era      = csr.csr_era;
            st_d.ecode    = csr.csr_ecode;
            st_d.esubcode = csr.csr_esubcode;
            if (csr.va_error) st_d.badv = csr.bad_va;
            if (csr.excp_tlbrefill) begin
                st_d.da = 1'b1;
                st_d.pg = 1'b0;
            end
        end else if (csr.ertn_flush) begin
            st_d.plv = st_q.pplv;
            st_d.ie  = st_q.pie;
            // Returning from a TLB refill handler re-enables mapped translation.
            if (st_q.ecode == 6'h3F) begin
                st_d.da = 1'b0;
                st_d.pg = 1'b1;
            end
            if (st_q.klo) st_d.klo   = 1'b0;
            else          st_d.llbit = 1'b0;
        end else if (wr) begin
            case (csr.wr_csr_addr)
                CSR_CRMD:      {st_d.pg, st_d.da, st_d.ie, st_d.plv} = wd[4:0];
                CSR_PRMD:      {st_d.pie, st_d.pplv} = wd[2:0];
                CSR_ECFG:      st_d.lie = wd[12:0] & 13'h1BFF;
                CSR_ESTAT:     st_d.estat_is[1:0] = wd[1:0];
                CSR_ERA:       st_d.era = wd;
                CSR_BADV:      st_d.badv = wd;
                CSR_EENTRY:    st_d.eentry = wd[31:6];
                CSR_SAVE0:     st_d.save[0] = wd;
                CSR_SAVE1:     st_d.save[1] = wd;
                CSR_SAVE2:     st_d.save[2] = wd;
                CSR_SAVE3:     st_d.save[3] = wd;
                CSR_TID:       st_d.tid = wd;
                CSR_TCFG:      {st_d.tcfg_init, st_d.tcfg_per, st_d.tcfg_en} = wd;
                CSR_LLBCTL: begin
                    st_d.klo = wd[2];
                    if (wd[1]) st_d.llbit = 1'b0;
                end
                CSR_TLBRENTRY: st_d.tlbrentry = wd[31:6];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q    <= '0;
            st_q.da <= 1'b1;
        end else begin
            st_q    <= st_d;
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (csr.rd_addr)
            CSR_CRMD:      rd_val = {27'd0, st_q.pg, st_q.da, st_q.ie, st_q.plv};
            CSR_PRMD:      rd_val = {29'd0, st_q.pie, st_q.pplv};
            CSR_ECFG:      rd_val = {19'd0, st_q.lie};
            CSR_ESTAT:     rd_val = {1'b0, st_q.esubcode, st_q.ecode, 3'd0, st_q.estat_is};
            CSR_ERA:       rd_val = st_q.era;
            CSR_BADV:      rd_val = st_q.badv;
            CSR_EENTRY:    rd_val = {st_q.eentry, 6'd0};
            CSR_SAVE0:     rd_val = st_q.save[0];
            CSR_SAVE1:     rd_val = st_q.save[1];
            CSR_SAVE2:     rd_val = st_q.save[2];
            CSR_SAVE3:     rd_val = st_q.save[3];
            CSR_TID:       rd_val = st_q.tid;
            CSR_TCFG:      rd_val = {st_q.tcfg_init, st_q.tcfg_per, st_q.tcfg_en};
            CSR_TVAL:      rd_val = st_q.tval;
            CSR_LLBCTL:    rd_val = {29'd0, st_q.klo, 1'b0, st_q.llbit};
            CSR_TLBRENTRY: rd_val = {st_q.tlbrentry, 6'd0};
            default:       rd_val = 32'd0;
        endcase
    end

    assign csr.rd_data    = rd_val;
    assign csr.excp_entry = csr.excp_tlbrefill ? {st_q.tlbrentry, 6'd0} : {st_q.eentry, 6'd0};
    assign csr.ertn_pc    = st_q.era;
    assign csr.has_int    = st_q.ie && |(st_q.estat_is & st_q.lie);
    assign csr.llbit      = st_q.llbit;
    assign csr.crmd_plv   = st_q.plv;
endmodule
